// File: rtl/downconv_pkg.sv
// Shared widths, fixed-point constants and arithmetic helpers for the stride-2
// 3x3 convolution downsampler.
package downconv_pkg;

   localparam int PIX_W       = 9;
   localparam int COEF_W      = 11;
   localparam int BIAS_W      = 20;
   localparam int PROD_W      = 20;
   localparam int ACC_W       = 25;
   localparam int FRAC_BITS   = 10;
   localparam int ROUND_CONST = 512;
   localparam int SAT_MAX     = 255;
   localparam int SAT_MIN     = -255;
   localparam int NTAPS       = 9;

   typedef logic signed [PIX_W-1:0]  pix_t;
   typedef logic signed [COEF_W-1:0] coef_t;
   typedef logic signed [PROD_W-1:0] prod_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   // Valid tag that rides alongside the data through the pipeline.
   typedef struct packed {
      logic valid;
      logic last;
   } tag_t;

   function automatic prod_t mul_pix_coef(input pix_t p, input coef_t k);
      prod_t pe;
      prod_t ke;
      pe = prod_t'(p);
      ke = prod_t'(k);
      return pe * ke;
   endfunction

   // Round half-up at the Q.10 point, then clamp symmetrically so -256 never appears.
   function automatic pix_t round_sat(input acc_t acc);
      acc_t rnd;
      acc_t shf;
      rnd = acc + acc_t'(ROUND_CONST);
      shf = rnd >>> FRAC_BITS;
      if (shf > acc_t'(SAT_MAX)) begin
         return pix_t'(SAT_MAX);
      end else if (shf < acc_t'(SAT_MIN)) begin
         return pix_t'(SAT_MIN);
      end else begin
         return pix_t'(shf);
      end
   endfunction

endpackage

// File: rtl/downconv_line_buffer.sv
// Circular line delay: dout_o is the sample written DEPTH enables earlier.
module downconv_line_buffer
   import downconv_pkg::*;
#(
   parameter int DEPTH = 128,
   parameter int WIDTH = 9
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    ptr_q;
   logic [AW-1:0]    ptr_d;

   assign dout_o = mem_q[ptr_q];

   // Pointer advance with wrap at DEPTH.
   always_comb begin
      ptr_d = ptr_q;
      if (en_i) begin
         if (ptr_q == AW'(DEPTH - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = ptr_q + AW'(1);
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Storage is intentionally not reset; stale lines are masked by padding downstream.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         mem_q[ptr_q] <= din_i;
      end
   end

endmodule

// File: rtl/downconv_s2_128x128.sv
// Stride-2 3x3 convolution downsampler, IMG_W x IMG_H -> half size, 4-cycle latency.
// Build option DOWNCONV_RELU_EN: clamp negative results to 0 after saturation.
module downconv_s2_128x128
   import downconv_pkg::*;
#(
   parameter int IMG_W = 128,
   parameter int IMG_H = 128
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     de,
   input  logic signed [PIX_W-1:0]  data_in,
   input  logic signed [COEF_W-1:0] k1,
   input  logic signed [COEF_W-1:0] k2,
   input  logic signed [COEF_W-1:0] k3,
   input  logic signed [COEF_W-1:0] k4,
   input  logic signed [COEF_W-1:0] k5,
   input  logic signed [COEF_W-1:0] k6,
   input  logic signed [COEF_W-1:0] k7,
   input  logic signed [COEF_W-1:0] k8,
   input  logic signed [COEF_W-1:0] k9,
   input  logic signed [BIAS_W-1:0] bias,
   output logic                     de_o,
   output logic signed [PIX_W-1:0]  data,
   output logic                     eof_o
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          qual_s, pad_top_s, pad_left_s, last_s;

   pix_t  lb1_s, lb2_s;
   pix_t  win_q [3][3];
   logic  pad_top_q, pad_left_q;
   tag_t  tag1_q, tag2_q, tag3_q;
   coef_t coef_s [NTAPS];
   pix_t  tap_s  [NTAPS];
   prod_t prod_q [NTAPS];
   acc_t  sum_s, acc_q;
   pix_t  sat_s, res_s, data_d, data_q;
   logic  de_d, de_q, eof_d, eof_q;

   assign coef_s = '{k1, k2, k3, k4, k5, k6, k7, k8, k9};

   downconv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
      .clk_i  (clk),
      .rst_i  (rst),
      .en_i   (de),
      .din_i  (data_in),
      .dout_o (lb1_s)
   );

   downconv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
      .clk_i  (clk),
      .rst_i  (rst),
      .en_i   (de),
      .din_i  (lb1_s),
      .dout_o (lb2_s)
   );

   assign qual_s     = de && col_q[0] && row_q[0];
   assign pad_top_s  = (row_q == RW'(1));
   assign pad_left_s = (col_q == CW'(1));
   assign last_s     = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

   // Raster position counters, advancing only on de and wrapping per frame.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (de) begin
         if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            if (row_q == RW'(IMG_H - 1)) begin
               row_d = '0;
            end else begin
               row_d = row_q + RW'(1);
            end
         end else begin
            col_d = col_q + CW'(1);
         end
      end else begin
         col_d = col_q;
         row_d = row_q;
      end
   end

   // Stage 1: counters, 3x3 window shift on de, and the qualifying-pixel tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q      <= '0;
         row_q      <= '0;
         pad_top_q  <= 1'b0;
         pad_left_q <= 1'b0;
         tag1_q     <= '0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         pad_top_q    <= pad_top_s;
         pad_left_q   <= pad_left_s;
         tag1_q.valid <= qual_s;
         tag1_q.last  <= qual_s && last_s;
         if (de) begin
            for (int r = 0; r < 3; r++) begin
               win_q[r][0] <= win_q[r][1];
               win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb2_s;
            win_q[1][2] <= lb1_s;
            win_q[2][2] <= data_in;
         end
      end
   end

   // Top/left zero padding; row 0 of the window is the oldest line.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            if ((pad_top_q && (r == 0)) || (pad_left_q && (c == 0))) begin
               tap_s[3*r + c] = '0;
            end else begin
               tap_s[3*r + c] = win_q[r][c];
            end
         end
      end
   end

   // Adder tree with bias, sign-extended into the accumulator width.
   always_comb begin
      sum_s = acc_t'(bias);
      for (int n = 0; n < NTAPS; n++) begin
         sum_s = sum_s + acc_t'(prod_q[n]);
      end
   end

   assign sat_s = round_sat(acc_q);

`ifdef DOWNCONV_RELU_EN
   assign res_s = sat_s[PIX_W-1] ? pix_t'(0) : sat_s;
`else
   assign res_s = sat_s;
`endif

   // Output next-state; data is held at zero whenever no pixel is emitted.
   always_comb begin
      de_d  = tag3_q.valid;
      eof_d = tag3_q.valid && tag3_q.last;
      if (tag3_q.valid) begin
         data_d = res_s;
      end else begin
         data_d = '0;
      end
   end

   // Stages 2-4: products, accumulator, output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag2_q <= '0;
         tag3_q <= '0;
         acc_q  <= '0;
         de_q   <= 1'b0;
         eof_q  <= 1'b0;
         data_q <= '0;
         for (int n = 0; n < NTAPS; n++) begin
            prod_q[n] <= '0;
         end
      end else begin
         tag2_q <= tag1_q;
         tag3_q <= tag2_q;
         acc_q  <= sum_s;
         de_q   <= de_d;
         eof_q  <= eof_d;
         data_q <= data_d;
         for (int n = 0; n < NTAPS; n++) begin
            prod_q[n] <= mul_pix_coef(tap_s[n], coef_s[n]);
         end
      end
   end

   assign de_o  = de_q;
   assign eof_o = eof_q;
   assign data  = data_q;

endmodule

// File: tb/tb_downconv_s2_128x128.sv
// Self-checking bench for downconv_s2_128x128: directed frames plus random
// image/coefficient/gap stimulus against a direct 3x3 stride-2 convolution model.
module tb_downconv_s2_128x128;

   localparam int W = 128;
   localparam int H = 128;

`ifdef DOWNCONV_RELU_EN
   localparam int NEG_SAT = 0;
   localparam int NEG_ONE = 0;
`else
   localparam int NEG_SAT = -255;
   localparam int NEG_ONE = -1;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic               de;
   logic signed [8:0]  data_in;
   logic signed [10:0] k1, k2, k3, k4, k5, k6, k7, k8, k9;
   logic signed [19:0] bias;
   logic               de_o;
   logic signed [8:0]  data;
   logic               eof_o;

   typedef struct {
      int val;
      bit eof;
      int cyc;
      int i;
      int j;
   } exp_t;

   int   kv [9];
   int   bv;
   int   img [H][W];
   int   out_cap [H/2][W/2];
   exp_t exp_q [$];
   int   cyc     = 0;
   int   total   = 0;
   int   bad     = 0;
   int   eof_cnt = 0;
   int   n_out   = 0;
   bit   mon_en  = 1'b0;
   int   n0, e0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign k1 = 11'(kv[0]);
   assign k2 = 11'(kv[1]);
   assign k3 = 11'(kv[2]);
   assign k4 = 11'(kv[3]);
   assign k5 = 11'(kv[4]);
   assign k6 = 11'(kv[5]);
   assign k7 = 11'(kv[6]);
   assign k8 = 11'(kv[7]);
   assign k9 = 11'(kv[8]);
   assign bias = 20'(bv);

   downconv_s2_128x128 dut (
      .clk     (clk),
      .rst     (rst),
      .de      (de),
      .data_in (data_in),
      .k1      (k1),
      .k2      (k2),
      .k3      (k3),
      .k4      (k4),
      .k5      (k5),
      .k6      (k6),
      .k7      (k7),
      .k8      (k8),
      .k9      (k9),
      .bias    (bias),
      .de_o    (de_o),
      .data    (data),
      .eof_o   (eof_o)
   );

   // Output (i,j) is the 3x3 neighbourhood of input (2i,2j), zero outside the image.
   function automatic int ref_px(input int i, input int j);
      longint s;
      int rr, cc;
      s = bv;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            rr = 2*i + dr;
            cc = 2*j + dc;
            if (rr >= 0 && cc >= 0) s += longint'(img[rr][cc]) * kv[(dr+1)*3 + dc + 1];
         end
      end
      s = (s + 512) >>> 10;
      if (s > 255) s = 255;
      if (s < -255) s = -255;
`ifdef DOWNCONV_RELU_EN
      if (s < 0) s = 0;
`endif
      return int'(s);
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic set_k(input int others, input int center, input int b);
      for (int n = 0; n < 9; n++) kv[n] = others;
      kv[4] = center;
      bv = b;
   endtask

   task automatic fill(input int mode, input int v);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            case (mode)
               0:       img[r][c] = v;
               1:       img[r][c] = (c % 200) - 100;
               default: img[r][c] = int'($urandom_range(0, 511)) - 256;
            endcase
         end
      end
   endtask

   task automatic clear_cap();
      for (int i = 0; i < H/2; i++) begin
         for (int j = 0; j < W/2; j++) out_cap[i][j] = -9999;
      end
   endtask

   task automatic drive_frame(input int npix, input int gap_pct);
      exp_t e;
      int r, c;
      for (int p = 0; p < npix; p++) begin
         r = p / W;
         c = p % W;
         while (int'($urandom_range(0, 99)) < gap_pct) begin
            @(negedge clk);
            de = 1'b0;
            data_in = 9'($urandom);
         end
         @(negedge clk);
         de = 1'b1;
         data_in = 9'(img[r][c]);
         if ((r % 2 == 1) && (c % 2 == 1)) begin
            e.val = ref_px(r / 2, c / 2);
            e.eof = (r == H-1) && (c == W-1);
            e.cyc = cyc + 4;
            e.i   = r / 2;
            e.j   = c / 2;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic drain();
      @(negedge clk);
      de = 1'b0;
      for (int w = 0; w < 40 && exp_q.size() != 0; w++) @(negedge clk);
      chk("drain_pending", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      de  = 1'b0;
      exp_q.delete();
      repeat (n - 1) @(negedge clk);
      rst = 1'b0;
   endtask

   // Per-cycle check of de_o timing, data, eof_o against the scoreboard.
   always @(posedge clk) begin : mon
      exp_t e;
      bit   due;
      #2;
      if (mon_en) begin
         due = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
         total++;
         assert (de_o === due) else begin
            bad++;
            $error("FAIL de_o cyc=%0d got=%b exp=%b", cyc, de_o, due);
         end
         if (de_o === 1'b1) n_out++;
         if (eof_o === 1'b1) eof_cnt++;
         if (due) begin
            e = exp_q.pop_front();
            total++;
            assert (data === 9'(e.val)) else begin
               bad++;
               $error("FAIL data out(%0d,%0d) got=%0d exp=%0d", e.i, e.j, data, e.val);
            end
            total++;
            assert (eof_o === e.eof) else begin
               bad++;
               $error("FAIL eof_o out(%0d,%0d) got=%b exp=%b", e.i, e.j, eof_o, e.eof);
            end
            out_cap[e.i][e.j] = int'(data);
         end else begin
            total++;
            assert (data === 9'sd0 && eof_o === 1'b0) else begin
               bad++;
               $error("FAIL idle_out cyc=%0d got data=%0d eof=%b exp data=0 eof=0", cyc, data, eof_o);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      de = 1'b0;
      data_in = '0;
      set_k(0, 0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      total++;
      assert (de_o === 1'b0 && eof_o === 1'b0 && data === 9'sd0) else begin
         bad++;
         $error("FAIL reset_state got de_o=%b eof_o=%b data=%0d exp 0/0/0", de_o, eof_o, data);
      end
      mon_en = 1'b1;

      // 1024 does not fit signed Q1.10; 1023 yields the same rounded results here.
      set_k(1023, 1023, 0);
      fill(0, 1);
      clear_cap();
      drive_frame(4*W, 0);
      drain();
      chk("pad_corner", out_cap[0][0], 4);
      chk("pad_row0", out_cap[0][20], 6);
      chk("pad_row0_right", out_cap[0][63], 6);
      chk("pad_col0", out_cap[1][0], 6);
      chk("pad_interior", out_cap[1][33], 9);

      do_reset(2);
      fill(0, 255);
      clear_cap();
      drive_frame(4*W, 0);
      drain();
      chk("sat_pos_corner", out_cap[0][0], 255);
      chk("sat_pos_int", out_cap[1][40], 255);

      do_reset(2);
      fill(0, -256);
      clear_cap();
      drive_frame(4*W, 0);
      drain();
      chk("sat_neg_corner", out_cap[0][0], NEG_SAT);
      chk("sat_neg_int", out_cap[1][17], NEG_SAT);

      do_reset(2);
      set_k(0, 512, 0);
      fill(0, 3);
      clear_cap();
      drive_frame(2*W, 0);
      drain();
      chk("round_p3", out_cap[0][10], 2);

      do_reset(2);
      fill(0, -3);
      clear_cap();
      drive_frame(2*W, 0);
      drain();
      chk("round_m3", out_cap[0][10], NEG_ONE);

      do_reset(2);
      set_k(0, 512, -1024);
      fill(0, 1);
      clear_cap();
      drive_frame(2*W, 0);
      drain();
      chk("round_bias", out_cap[0][10], 0);

      // Identity frame, then the same frame with 50% de gaps, back to back.
      do_reset(2);
      set_k(0, 1023, 0);
      fill(1, 0);
      clear_cap();
      n0 = n_out;
      e0 = eof_cnt;
      drive_frame(H*W, 0);
      drive_frame(H*W, 50);
      drain();
      chk("ident_count", n_out - n0, 2 * (W/2) * (H/2));
      chk("ident_eof", eof_cnt - e0, 2);
      chk("ident_0_0", out_cap[0][0], -100);
      chk("ident_10_50", out_cap[10][50], 0);
      chk("ident_63_63", out_cap[63][63], 26);

      // Random coefficients; reset in the middle of line 40, then a full random frame.
      for (int n = 0; n < 9; n++) kv[n] = int'($urandom_range(0, 511)) - 256;
      bv = int'($urandom_range(0, 131071)) - 65536;
      fill(2, 0);
      drive_frame(40*W + 77, 0);
      do_reset(2);
      repeat (10) @(negedge clk);
      fill(2, 0);
      n0 = n_out;
      e0 = eof_cnt;
      drive_frame(H*W, 20);
      drain();
      chk("rand_count", n_out - n0, (W/2) * (H/2));
      chk("rand_eof", eof_cnt - e0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
